mem_stage: RTL and testbench

MEM_STAGE -- requirements
Module: mem_stage

---
 rtl/mem_stage.sv | 233 +++++++++++++++++++++++
 tb/tb_mem_stage.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage.sv
// Memory stage: issues one data-memory request at a time for loads and
// stores, waits for the completion pulse, and registers the retired result
// into mem_wb_reg. Non-memory and misaligned ops go straight through in
// one cycle.

package mem_stage_pkg;

  localparam logic [6:0] op_b_load  = 7'b0000011;
  localparam logic [6:0] op_b_store = 7'b0100011;
  localparam logic [6:0] op_b_lui   = 7'b0110111;
  localparam logic [6:0] op_b_imm   = 7'b0010011;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [31:0] mem_addr;
    logic [31:0] rs2_v;
    logic [4:0]  rd_s;
    logic [31:0] rd_v;
    logic        regf_we;
    logic        commit;
  } ex_mem_reg_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic [4:0]  rd_s;
    logic [31:0] rd_v;
    logic        regf_we;
    logic        commit;
    logic [31:0] mem_addr;
    logic [3:0]  mem_rmask;
    logic [3:0]  mem_wmask;
    logic [31:0] mem_rdata;
    logic [31:0] mem_wdata;
  } mem_wb_reg_t;

endpackage

module mem_stage
  import mem_stage_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  ex_mem_reg_t ex_mem_reg,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_rmask,
  output logic [3:0]  dmem_wmask,
  output logic [31:0] dmem_wdata,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_resp,
  output mem_wb_reg_t mem_wb_reg,
  output logic        stall
);

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  // Everything the in-flight op needs to retire; upstream may change
  // ex_mem_reg while we wait, so only this copy is used in S_WAIT.
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic [4:0]  rd_s;
    logic [31:0] rd_v;
    logic [2:0]  funct3;
    logic        is_load;
    logic [1:0]  offset;
    logic [31:0] addr;
    logic [3:0]  rmask;
    logic [3:0]  wmask;
    logic [31:0] wdata;
  } req_t;

  state_t      state_reg, state_next;
  req_t        req_reg, req_next;
  mem_wb_reg_t wb_next;

  logic        is_load, is_store, is_mem, issue_ok;
  logic [1:0]  offset;
  logic [3:0]  lane_mask;
  logic [31:0] aligned_addr;

  // Byte lanes touched by an access of the given size at the given offset.
  function automatic logic [3:0] byte_mask(input logic [1:0] size, input logic [1:0] off);
    logic [3:0] m;
    case (size)
      2'b00:   m = 4'b0001 << off;
      2'b01:   m = 4'b0011 << off;
      2'b10:   m = 4'b1111;
      default: m = 4'b0000;
    endcase
    return m;
  endfunction

  // Legal encoding with natural alignment; anything else retires without a request.
  function automatic logic access_ok(input logic load, input logic [2:0] f3, input logic [1:0] off);
    logic ok;
    case (f3)
      3'b000:  ok = 1'b1;
      3'b001:  ok = ~off[0];
      3'b010:  ok = (off == 2'b00);
      3'b100:  ok = load;
      3'b101:  ok = load & ~off[0];
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

  // Replicate narrow store data across every lane so the mask alone selects.
  function automatic logic [31:0] store_data(input logic [1:0] size, input logic [31:0] v);
    logic [31:0] d;
    case (size)
      2'b00:   d = {4{v[7:0]}};
      2'b01:   d = {2{v[15:0]}};
      default: d = v;
    endcase
    return d;
  endfunction

  // Extract and extend the addressed bytes of a load response.
  function automatic logic [31:0] load_data(input logic [2:0] f3, input logic [1:0] off,
                                            input logic [31:0] rdata);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    b = rdata[{off, 3'b000} +: 8];
    h = off[1] ? rdata[31:16] : rdata[15:0];
    case (f3)
      3'b000:  r = {{24{b[7]}}, b};
      3'b100:  r = {24'b0, b};
      3'b001:  r = {{16{h[15]}}, h};
      3'b101:  r = {16'b0, h};
      default: r = rdata;
    endcase
    return r;
  endfunction

  assign is_load      = (ex_mem_reg.opcode == op_b_load);
  assign is_store     = (ex_mem_reg.opcode == op_b_store);
  assign is_mem       = is_load | is_store;
  assign offset       = ex_mem_reg.mem_addr[1:0];
  assign lane_mask    = byte_mask(ex_mem_reg.funct3[1:0], offset);
  assign issue_ok     = is_mem & access_ok(is_load, ex_mem_reg.funct3, offset);
  assign aligned_addr = {ex_mem_reg.mem_addr[31:2], 2'b00};

  // State, request and writeback registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= S_IDLE;
      req_reg    <= '0;
      mem_wb_reg <= '0;
    end else begin
      state_reg  <= state_next;
      req_reg    <= req_next;
      mem_wb_reg <= wb_next;
    end
  end

  // Next state, request issue, stall and writeback value.
  always_comb begin
    state_next = state_reg;
    req_next   = req_reg;
    wb_next    = '0;
    dmem_addr  = req_reg.addr;
    dmem_rmask = 4'b0000;
    dmem_wmask = 4'b0000;
    dmem_wdata = 32'h0;
    stall      = 1'b0;

    case (state_reg)
      S_IDLE: begin
        if (ex_mem_reg.commit) begin
          if (issue_ok) begin
            dmem_addr  = aligned_addr;
            dmem_rmask = is_load  ? lane_mask : 4'b0000;
            dmem_wmask = is_store ? lane_mask : 4'b0000;
            dmem_wdata = is_store ? store_data(ex_mem_reg.funct3[1:0], ex_mem_reg.rs2_v) : 32'h0;
            stall      = 1'b1;
            req_next.pc      = ex_mem_reg.pc;
            req_next.inst    = ex_mem_reg.inst;
            req_next.rd_s    = ex_mem_reg.rd_s;
            req_next.rd_v    = ex_mem_reg.rd_v;
            req_next.funct3  = ex_mem_reg.funct3;
            req_next.is_load = is_load;
            req_next.offset  = offset;
            req_next.addr    = aligned_addr;
            req_next.rmask   = is_load  ? lane_mask : 4'b0000;
            req_next.wmask   = is_store ? lane_mask : 4'b0000;
            req_next.wdata   = is_store ? store_data(ex_mem_reg.funct3[1:0], ex_mem_reg.rs2_v) : 32'h0;
            state_next       = S_WAIT;
          end else begin
            // Pass-through, or a memory op that cannot be issued.
            wb_next.pc       = ex_mem_reg.pc;
            wb_next.inst     = ex_mem_reg.inst;
            wb_next.rd_s     = ex_mem_reg.rd_s;
            wb_next.rd_v     = ex_mem_reg.rd_v;
            wb_next.regf_we  = is_mem ? 1'b0 : ex_mem_reg.regf_we;
            wb_next.commit   = 1'b1;
            wb_next.mem_addr = ex_mem_reg.mem_addr;
          end
        end
      end

      S_WAIT: begin
        stall = ~dmem_resp;
        if (dmem_resp) begin
          wb_next.pc        = req_reg.pc;
          wb_next.inst      = req_reg.inst;
          wb_next.rd_s      = req_reg.rd_s;
          wb_next.rd_v      = req_reg.is_load ?
                              load_data(req_reg.funct3, req_reg.offset, dmem_rdata) : req_reg.rd_v;
          wb_next.regf_we   = req_reg.is_load;
          wb_next.commit    = 1'b1;
          wb_next.mem_addr  = req_reg.addr;
          wb_next.mem_rmask = req_reg.rmask;
          wb_next.mem_wmask = req_reg.wmask;
          wb_next.mem_rdata = req_reg.is_load ? dmem_rdata : 32'h0;
          wb_next.mem_wdata = req_reg.wdata;
          state_next        = S_IDLE;
        end
      end
    endcase

    if (rst) begin
      stall      = 1'b0;
      dmem_rmask = 4'b0000;
      dmem_wmask = 4'b0000;
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: expected retirements are queued when an op is
// driven and compared field by field whenever mem_wb_reg shows a commit.

module tb_mem_stage;
  import mem_stage_pkg::*;

  localparam logic [2:0] F_B  = 3'b000;
  localparam logic [2:0] F_H  = 3'b001;
  localparam logic [2:0] F_W  = 3'b010;
  localparam logic [2:0] F_HU = 3'b101;

  logic        clk;
  logic        rst;
  ex_mem_reg_t ex_mem_reg;
  logic [31:0] dmem_addr;
  logic [3:0]  dmem_rmask;
  logic [3:0]  dmem_wmask;
  logic [31:0] dmem_wdata;
  logic [31:0] dmem_rdata;
  logic        dmem_resp;
  mem_wb_reg_t mem_wb_reg;
  logic        stall;

  int total = 0;
  int bad   = 0;
  mem_wb_reg_t sb[$];

  mem_stage dut (
    .clk        (clk),
    .rst        (rst),
    .ex_mem_reg (ex_mem_reg),
    .dmem_addr  (dmem_addr),
    .dmem_rmask (dmem_rmask),
    .dmem_wmask (dmem_wmask),
    .dmem_wdata (dmem_wdata),
    .dmem_rdata (dmem_rdata),
    .dmem_resp  (dmem_resp),
    .mem_wb_reg (mem_wb_reg),
    .stall      (stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic ex_mem_reg_t mk_ex(input logic c, input logic [6:0] op, input logic [2:0] f3,
                                        input logic [31:0] addr, input logic [31:0] rs2,
                                        input logic [31:0] rdv, input logic [31:0] pc);
    ex_mem_reg_t e;
    e          = '0;
    e.commit   = c;
    e.opcode   = op;
    e.funct3   = f3;
    e.mem_addr = addr;
    e.rs2_v    = rs2;
    e.rd_v     = rdv;
    e.pc       = pc;
    e.inst     = pc ^ 32'h0badf00d;
    e.rd_s     = pc[6:2];
    e.regf_we  = (op != op_b_store);
    return e;
  endfunction

  function automatic mem_wb_reg_t mk_wb(input ex_mem_reg_t e, input logic [31:0] rdv, input logic we,
                                        input logic [31:0] addr, input logic [3:0] rm,
                                        input logic [3:0] wm, input logic [31:0] rdata,
                                        input logic [31:0] wdata);
    mem_wb_reg_t w;
    w.pc        = e.pc;
    w.inst      = e.inst;
    w.rd_s      = e.rd_s;
    w.rd_v      = rdv;
    w.regf_we   = we;
    w.commit    = 1'b1;
    w.mem_addr  = addr;
    w.mem_rmask = rm;
    w.mem_wmask = wm;
    w.mem_rdata = rdata;
    w.mem_wdata = wdata;
    return w;
  endfunction

  // Pop and compare whenever the DUT retires something.
  task automatic check_wb();
    mem_wb_reg_t e;
    if (mem_wb_reg.commit === 1'b1) begin
      chk("retire_expected", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("wb_pc",        mem_wb_reg.pc,               e.pc);
        chk("wb_inst",      mem_wb_reg.inst,             e.inst);
        chk("wb_rd_s",      32'(mem_wb_reg.rd_s),        32'(e.rd_s));
        chk("wb_rd_v",      mem_wb_reg.rd_v,             e.rd_v);
        chk("wb_regf_we",   32'(mem_wb_reg.regf_we),     32'(e.regf_we));
        chk("wb_mem_addr",  mem_wb_reg.mem_addr,         e.mem_addr);
        chk("wb_mem_rmask", 32'(mem_wb_reg.mem_rmask),   32'(e.mem_rmask));
        chk("wb_mem_wmask", 32'(mem_wb_reg.mem_wmask),   32'(e.mem_wmask));
        chk("wb_mem_rdata", mem_wb_reg.mem_rdata,        e.mem_rdata);
        chk("wb_mem_wdata", mem_wb_reg.mem_wdata,        e.mem_wdata);
        $display("retire pc=%h rd_v=%h we=%0d addr=%h rm=%b wm=%b",
                 mem_wb_reg.pc, mem_wb_reg.rd_v, mem_wb_reg.regf_we,
                 mem_wb_reg.mem_addr, mem_wb_reg.mem_rmask, mem_wb_reg.mem_wmask);
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    check_wb();
  endtask

  initial begin
    rst        = 1'b1;
    ex_mem_reg = '0;
    dmem_rdata = 32'h0;
    dmem_resp  = 1'b0;
    tick();

    // Reset: outputs quiet even with a memory op presented.
    ex_mem_reg = mk_ex(1'b1, op_b_load, F_B, 32'h1003, 32'h0, 32'h0, 32'h80);
    #1;
    chk("rst_stall", 32'(stall), 32'd0);
    chk("rst_rmask", 32'(dmem_rmask), 32'd0);
    chk("rst_wmask", 32'(dmem_wmask), 32'd0);
    tick();
    chk("rst_commit",  32'(mem_wb_reg.commit), 32'd0);
    chk("rst_regf_we", 32'(mem_wb_reg.regf_we), 32'd0);
    chk("rst_wb_rd_v", mem_wb_reg.rd_v, 32'h0);
    rst = 1'b0;

    // Pass-through lui.
    ex_mem_reg = mk_ex(1'b1, op_b_lui, F_B, 32'h0, 32'h0, 32'h12345000, 32'h100);
    sb.push_back(mk_wb(ex_mem_reg, 32'h12345000, 1'b1, 32'h0, 4'h0, 4'h0, 32'h0, 32'h0));
    #1;
    chk("lui_stall", 32'(stall), 32'd0);
    chk("lui_rmask", 32'(dmem_rmask), 32'd0);
    chk("lui_wmask", 32'(dmem_wmask), 32'd0);
    tick();
    chk("lui_drained", 32'(sb.size()), 32'd0);

    // lb at 0x1003, response three cycles after issue.
    ex_mem_reg = mk_ex(1'b1, op_b_load, F_B, 32'h1003, 32'h0, 32'hdeadbeef, 32'h104);
    sb.push_back(mk_wb(ex_mem_reg, 32'hffffff80, 1'b1, 32'h1000, 4'b1000, 4'h0, 32'h80ffffff, 32'h0));
    #1;
    chk("lb_addr",  dmem_addr, 32'h1000);
    chk("lb_rmask", 32'(dmem_rmask), 32'h8);
    chk("lb_wmask", 32'(dmem_wmask), 32'h0);
    chk("lb_stall", 32'(stall), 32'd1);
    tick();
    chk("lb_issue_bubble", 32'(mem_wb_reg.commit), 32'd0);
    // Input changes during the wait must not disturb the in-flight op.
    ex_mem_reg = mk_ex(1'b1, op_b_store, F_W, 32'h5000, 32'h55555555, 32'h0, 32'h200);
    for (int i = 0; i < 2; i++) begin
      #1;
      chk("lb_wait_stall", 32'(stall), 32'd1);
      chk("lb_wait_rmask", 32'(dmem_rmask), 32'd0);
      chk("lb_wait_wmask", 32'(dmem_wmask), 32'd0);
      tick();
      chk("lb_wait_bubble", 32'(mem_wb_reg.commit), 32'd0);
    end
    dmem_resp  = 1'b1;
    dmem_rdata = 32'h80ffffff;
    ex_mem_reg = '0;
    #1;
    chk("lb_resp_stall", 32'(stall), 32'd0);
    tick();
    dmem_resp  = 1'b0;
    dmem_rdata = 32'h0;
    chk("lb_drained", 32'(sb.size()), 32'd0);

    // sh at 0x2002, response in the following cycle.
    ex_mem_reg = mk_ex(1'b1, op_b_store, F_H, 32'h2002, 32'haaaabeef, 32'h11111111, 32'h108);
    sb.push_back(mk_wb(ex_mem_reg, 32'h11111111, 1'b0, 32'h2000, 4'h0, 4'b1100, 32'h0, 32'hbeefbeef));
    #1;
    chk("sh_addr",  dmem_addr, 32'h2000);
    chk("sh_wmask", 32'(dmem_wmask), 32'hc);
    chk("sh_rmask", 32'(dmem_rmask), 32'h0);
    chk("sh_wdata", dmem_wdata, 32'hbeefbeef);
    chk("sh_stall", 32'(stall), 32'd1);
    tick();
    chk("sh_issue_bubble", 32'(mem_wb_reg.commit), 32'd0);
    dmem_resp  = 1'b1;
    dmem_rdata = 32'hffffffff;
    ex_mem_reg = '0;
    #1;
    chk("sh_resp_stall", 32'(stall), 32'd0);
    tick();
    dmem_resp = 1'b0;
    chk("sh_drained", 32'(sb.size()), 32'd0);

    // Misaligned lw: no request, one-cycle retire with regf_we=0.
    ex_mem_reg = mk_ex(1'b1, op_b_load, F_W, 32'h3001, 32'h0, 32'h22222222, 32'h10c);
    sb.push_back(mk_wb(ex_mem_reg, 32'h22222222, 1'b0, 32'h3001, 4'h0, 4'h0, 32'h0, 32'h0));
    #1;
    chk("mis_rmask", 32'(dmem_rmask), 32'd0);
    chk("mis_wmask", 32'(dmem_wmask), 32'd0);
    chk("mis_stall", 32'(stall), 32'd0);
    tick();
    chk("mis_drained", 32'(sb.size()), 32'd0);

    // sb at 0x1001: single lane, replicated data.
    ex_mem_reg = mk_ex(1'b1, op_b_store, F_B, 32'h1001, 32'h1234565a, 32'h33333333, 32'h110);
    sb.push_back(mk_wb(ex_mem_reg, 32'h33333333, 1'b0, 32'h1000, 4'h0, 4'b0010, 32'h0, 32'h5a5a5a5a));
    #1;
    chk("sb_wmask", 32'(dmem_wmask), 32'h2);
    chk("sb_wdata", dmem_wdata, 32'h5a5a5a5a);
    tick();
    dmem_resp  = 1'b1;
    ex_mem_reg = '0;
    tick();
    dmem_resp = 1'b0;
    chk("sb_drained", 32'(sb.size()), 32'd0);

    // Uncommitted memory op: bubble, no request.
    ex_mem_reg = mk_ex(1'b0, op_b_load, F_W, 32'h4000, 32'h0, 32'h0, 32'h114);
    #1;
    chk("nocommit_rmask", 32'(dmem_rmask), 32'd0);
    chk("nocommit_stall", 32'(stall), 32'd0);
    tick();
    chk("nocommit_bubble", 32'(mem_wb_reg.commit), 32'd0);

    // Stray response while idle is ignored.
    ex_mem_reg = '0;
    dmem_resp  = 1'b1;
    dmem_rdata = 32'hffffffff;
    #1;
    chk("idle_resp_stall", 32'(stall), 32'd0);
    tick();
    chk("idle_resp_bubble", 32'(mem_wb_reg.commit), 32'd0);
    dmem_resp = 1'b0;

    // Back-to-back lw then lhu; upstream holds lw while stalled.
    ex_mem_reg = mk_ex(1'b1, op_b_load, F_W, 32'h4000, 32'h0, 32'h0, 32'h118);
    sb.push_back(mk_wb(ex_mem_reg, 32'h12345678, 1'b1, 32'h4000, 4'hf, 4'h0, 32'h12345678, 32'h0));
    #1;
    chk("b2b_lw_rmask", 32'(dmem_rmask), 32'hf);
    chk("b2b_lw_addr",  dmem_addr, 32'h4000);
    chk("b2b_lw_stall", 32'(stall), 32'd1);
    tick();
    #1;
    chk("b2b_wait_rmask", 32'(dmem_rmask), 32'd0);
    chk("b2b_wait_stall", 32'(stall), 32'd1);
    tick();
    dmem_resp  = 1'b1;
    dmem_rdata = 32'h12345678;
    #1;
    chk("b2b_resp_rmask", 32'(dmem_rmask), 32'd0);
    chk("b2b_resp_stall", 32'(stall), 32'd0);
    tick();
    chk("b2b_lw_drained", 32'(sb.size()), 32'd0);
    dmem_resp  = 1'b0;
    dmem_rdata = 32'h0;
    ex_mem_reg = mk_ex(1'b1, op_b_load, F_HU, 32'h4002, 32'h0, 32'h0, 32'h11c);
    sb.push_back(mk_wb(ex_mem_reg, 32'h00008001, 1'b1, 32'h4000, 4'b1100, 4'h0, 32'h80010000, 32'h0));
    #1;
    chk("b2b_lhu_rmask", 32'(dmem_rmask), 32'hc);
    chk("b2b_lhu_stall", 32'(stall), 32'd1);
    tick();
    dmem_resp  = 1'b1;
    dmem_rdata = 32'h80010000;
    ex_mem_reg = '0;
    tick();
    dmem_resp = 1'b0;
    chk("b2b_lhu_drained", 32'(sb.size()), 32'd0);

    // Reset while waiting abandons the op; a late response is ignored.
    ex_mem_reg = mk_ex(1'b1, op_b_load, F_W, 32'h7000, 32'h0, 32'h0, 32'h120);
    tick();
    #1;
    chk("rw_wait_stall", 32'(stall), 32'd1);
    rst        = 1'b1;
    ex_mem_reg = '0;
    #1;
    chk("rw_rst_stall", 32'(stall), 32'd0);
    tick();
    chk("rw_rst_bubble", 32'(mem_wb_reg.commit), 32'd0);
    rst        = 1'b0;
    dmem_resp  = 1'b1;
    dmem_rdata = 32'hdeadbeef;
    #1;
    chk("rw_late_resp_stall", 32'(stall), 32'd0);
    tick();
    chk("rw_late_resp_bubble", 32'(mem_wb_reg.commit), 32'd0);
    dmem_resp = 1'b0;

    // Block is idle again: a new store issues at once.
    ex_mem_reg = mk_ex(1'b1, op_b_store, F_B, 32'h8000, 32'h000000a5, 32'h44444444, 32'h124);
    sb.push_back(mk_wb(ex_mem_reg, 32'h44444444, 1'b0, 32'h8000, 4'h0, 4'b0001, 32'h0, 32'ha5a5a5a5));
    #1;
    chk("post_rst_wmask", 32'(dmem_wmask), 32'h1);
    chk("post_rst_stall", 32'(stall), 32'd1);
    tick();
    dmem_resp  = 1'b1;
    ex_mem_reg = '0;
    tick();
    dmem_resp = 1'b0;
    tick();
    chk("final_drained", 32'(sb.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
